// File: rtl/score_disp_pkg.sv
// rtl/score_disp_pkg.sv - shared types and constants for the score display driver
package score_disp_pkg;

    typedef enum logic [1:0] {
        DIG_ONES     = 2'd0,
        DIG_TENS     = 2'd1,
        DIG_HUNDREDS = 2'd2
    } digit_e;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        BLINK_OFF = 2'd1,
        BLINK_ON  = 2'd2
    } blink_state_e;

    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Counter width for a 0..n-1 counter, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/score_display_driver_if.sv
// rtl/score_display_driver_if.sv - BCD digits in, multiplexed seven-segment bus out
interface score_display_driver_if;
    logic [3:0] bcd_ones;
    logic [3:0] bcd_tens;
    logic [3:0] bcd_hundreds;
    logic       isGameComplete;
    logic [6:0] seg;
    logic [2:0] an;
    logic       blinking;

    modport master (
        output bcd_ones, bcd_tens, bcd_hundreds, isGameComplete,
        input  seg, an, blinking
    );

    modport slave (
        input  bcd_ones, bcd_tens, bcd_hundreds, isGameComplete,
        output seg, an, blinking
    );
endinterface

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - 4-bit BCD to active-high {g,f,e,d,c,b,a} decoder
module bcd_to_seg7
    import score_disp_pkg::*;
(
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_DASH;
        case (bcd_i)
            4'd0:    seg_o = 7'h3F;
            4'd1:    seg_o = 7'h06;
            4'd2:    seg_o = 7'h5B;
            4'd3:    seg_o = 7'h4F;
            4'd4:    seg_o = 7'h66;
            4'd5:    seg_o = 7'h6D;
            4'd6:    seg_o = 7'h7D;
            4'd7:    seg_o = 7'h07;
            4'd8:    seg_o = 7'h7F;
            4'd9:    seg_o = 7'h6F;
            default: seg_o = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - 3-digit scanned display with frame snapshots and game-complete blink
// Optional leading-zero blanking: SCORE_DISP_LZB_EN.
module score_display_driver
    import score_disp_pkg::*;
#(
    parameter int SCAN_DIV    = 1000,
    parameter int BLINK_DIV   = 5_000_000,
    parameter int BLINK_COUNT = 3
) (
    input  logic                   clk,
    input  logic                   nRst,
    score_display_driver_if.slave  bus
);

    localparam int SCAN_W  = cnt_width(SCAN_DIV);
    localparam int BLINK_W = cnt_width(BLINK_DIV);
    localparam int PAIR_W  = cnt_width(BLINK_COUNT);

    localparam logic [SCAN_W-1:0]  SCAN_TC  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_TC = BLINK_W'(BLINK_DIV - 1);
    localparam logic [PAIR_W-1:0]  PAIR_TC  = PAIR_W'(BLINK_COUNT - 1);

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    digit_e             dig_q, dig_d;
    logic [3:0]         snap_ones_q, snap_tens_q, snap_hund_q;
    logic               gc_q;
    logic               rise_pend_q;
    blink_state_e       state_q, state_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic [PAIR_W-1:0]  pair_cnt_q, pair_cnt_d;
    logic [6:0]         seg_q, seg_d;
    logic [2:0]         an_q, an_d;
    logic               blinking_q, blinking_d;

    logic       tick, frame_bnd, rise, snap_load, blink_tc;
    logic [3:0] cur_digit;
    logic [6:0] dec_seg;

    assign tick      = (scan_cnt_q == SCAN_TC);
    assign frame_bnd = tick && (dig_q == DIG_HUNDREDS);
    assign rise      = bus.isGameComplete && !gc_q;
    // The tracker's BCD settles one cycle after isGameComplete, hence the delayed load.
    assign snap_load = frame_bnd || rise_pend_q;
    assign blink_tc  = (blink_cnt_q == BLINK_TC);

    always_comb begin
        scan_cnt_d = tick ? '0 : scan_cnt_q + 1'b1;
        dig_d      = dig_q;
        if (tick) begin
            case (dig_q)
                DIG_ONES: dig_d = DIG_TENS;
                DIG_TENS: dig_d = DIG_HUNDREDS;
                default:  dig_d = DIG_ONES;
            endcase
        end
    end

    always_comb begin
        state_d     = state_q;
        blink_cnt_d = blink_cnt_q;
        pair_cnt_d  = pair_cnt_q;
        if (rise) begin
            state_d     = BLINK_OFF;
            blink_cnt_d = '0;
            pair_cnt_d  = '0;
        end else begin
            case (state_q)
                BLINK_OFF: begin
                    if (blink_tc) begin
                        state_d     = BLINK_ON;
                        blink_cnt_d = '0;
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                BLINK_ON: begin
                    if (blink_tc) begin
                        blink_cnt_d = '0;
                        if (pair_cnt_q == PAIR_TC) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = BLINK_OFF;
                            pair_cnt_d = pair_cnt_q + 1'b1;
                        end
                    end else begin
                        blink_cnt_d = blink_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    blink_cnt_d = '0;
                    pair_cnt_d  = '0;
                end
            endcase
        end
    end

    bcd_to_seg7 u_dec (
        .bcd_i (cur_digit),
        .seg_o (dec_seg)
    );

    always_comb begin
        cur_digit = snap_ones_q;
        an_d      = 3'b001;
        case (dig_q)
            DIG_TENS: begin
                cur_digit = snap_tens_q;
                an_d      = 3'b010;
            end
            DIG_HUNDREDS: begin
                cur_digit = snap_hund_q;
                an_d      = 3'b100;
            end
            default: begin
                cur_digit = snap_ones_q;
                an_d      = 3'b001;
            end
        endcase
        seg_d = dec_seg;
`ifdef SCORE_DISP_LZB_EN
        if ((dig_q == DIG_HUNDREDS) && (snap_hund_q == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
        if ((dig_q == DIG_TENS) && (snap_hund_q == 4'd0) && (snap_tens_q == 4'd0)) begin
            seg_d = SEG_BLANK;
        end
`else
`endif
        blinking_d = (state_q != IDLE);
        if (state_q == BLINK_OFF) begin
            seg_d = SEG_BLANK;
            an_d  = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            scan_cnt_q  <= '0;
            dig_q       <= DIG_ONES;
            snap_ones_q <= 4'd0;
            snap_tens_q <= 4'd0;
            snap_hund_q <= 4'd0;
            gc_q        <= 1'b0;
            rise_pend_q <= 1'b0;
            state_q     <= IDLE;
            blink_cnt_q <= '0;
            pair_cnt_q  <= '0;
            seg_q       <= SEG_BLANK;
            an_q        <= 3'b000;
            blinking_q  <= 1'b0;
        end else begin
            scan_cnt_q  <= scan_cnt_d;
            dig_q       <= dig_d;
            if (snap_load) begin
                snap_ones_q <= bus.bcd_ones;
                snap_tens_q <= bus.bcd_tens;
                snap_hund_q <= bus.bcd_hundreds;
            end
            gc_q        <= bus.isGameComplete;
            rise_pend_q <= rise;
            state_q     <= state_d;
            blink_cnt_q <= blink_cnt_d;
            pair_cnt_q  <= pair_cnt_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            blinking_q  <= blinking_d;
        end
    end

    assign bus.seg      = seg_q;
    assign bus.an       = an_q;
    assign bus.blinking = blinking_q;

endmodule

// File: tb/tb_score_display_driver.sv
// tb/tb_score_display_driver.sv - directed self-checking bench for score_display_driver
module tb_score_display_driver;

    localparam int SCAN_DIV    = 4;
    localparam int BLINK_DIV   = 8;
    localparam int BLINK_COUNT = 2;
`ifdef SCORE_DISP_LZB_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic clk = 1'b0;
    logic nRst = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc;

    score_display_driver_if bus();

    score_display_driver #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_DIV   (BLINK_DIV),
        .BLINK_COUNT (BLINK_COUNT)
    ) dut (
        .clk  (clk),
        .nRst (nRst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // Rising edges since reset release; outputs after edge n show the slot ((n-1)/SCAN_DIV)%3.
    always @(posedge clk or negedge nRst) begin
        if (!nRst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    function automatic int slot_of(input int c);
        return ((c - 1) / SCAN_DIV) % 3;
    endfunction

    task automatic set_digits(input logic [3:0] h, input logic [3:0] t, input logic [3:0] o);
        bus.bcd_hundreds = h;
        bus.bcd_tens     = t;
        bus.bcd_ones     = o;
    endtask

    task automatic advance_to(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cyc != target) begin
            errors++;
            $display("FAIL advance_to cyc=%0d required=%0d", cyc, target);
        end
    endtask

    task automatic test_reset;
        nRst = 1'b0;
        bus.isGameComplete = 1'b0;
        set_digits(4'd1, 4'd2, 4'd3);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.seg !== 7'h00) begin errors++; $display("FAIL reset_seg got=%h exp=00", bus.seg); end
        checks++;
        if (bus.an !== 3'b000) begin errors++; $display("FAIL reset_an got=%b exp=000", bus.an); end
        checks++;
        if (bus.blinking !== 1'b0) begin errors++; $display("FAIL reset_blinking got=%b exp=0", bus.blinking); end
        nRst = 1'b1;
    endtask

    task automatic test_scan_order;
        logic [6:0] tab [3];
        logic [6:0] exp_seg;
        logic [2:0] exp_an;
        int s;
        tab[0] = 7'h4F; tab[1] = 7'h5B; tab[2] = 7'h06;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            s = slot_of(cyc);
            exp_an  = 3'b001 << s;
            exp_seg = (cyc <= 12) ? 7'h3F : tab[s];
            checks++;
            if (bus.an !== exp_an) begin
                errors++; $display("FAIL scan_an cyc=%0d got=%b exp=%b", cyc, bus.an, exp_an);
            end
            checks++;
            if (bus.seg !== exp_seg) begin
                errors++; $display("FAIL scan_seg cyc=%0d got=%h exp=%h", cyc, bus.seg, exp_seg);
            end
        end
    endtask

    task automatic test_no_tearing;
        logic [6:0] old_tab [3];
        logic [6:0] new_tab [3];
        logic [6:0] exp_seg;
        int s;
        old_tab[0] = 7'h4F; old_tab[1] = 7'h5B; old_tab[2] = 7'h06;
        new_tab[0] = 7'h07; new_tab[1] = 7'h7F; new_tab[2] = 7'h6F;
        advance_to(26);
        set_digits(4'd9, 4'd8, 4'd7);
        while (cyc < 48) begin
            @(negedge clk);
            s = slot_of(cyc);
            exp_seg = (cyc <= 36) ? old_tab[s] : new_tab[s];
            checks++;
            if (bus.seg !== exp_seg) begin
                errors++; $display("FAIL tearing_seg cyc=%0d got=%h exp=%h", cyc, bus.seg, exp_seg);
            end
        end
    endtask

    task automatic test_invalid_bcd;
        logic [6:0] old_tab [3];
        logic [6:0] new_tab [3];
        logic [6:0] exp_seg;
        int s;
        old_tab[0] = 7'h07; old_tab[1] = 7'h7F; old_tab[2] = 7'h6F;
        new_tab[0] = 7'h07; new_tab[1] = 7'h40; new_tab[2] = 7'h6F;
        advance_to(48);
        bus.bcd_tens = 4'hC;
        while (cyc < 72) begin
            @(negedge clk);
            s = slot_of(cyc);
            exp_seg = (cyc <= 60) ? old_tab[s] : new_tab[s];
            checks++;
            if (bus.seg !== exp_seg) begin
                errors++; $display("FAIL invalid_bcd_seg cyc=%0d got=%h exp=%h", cyc, bus.seg, exp_seg);
            end
        end
    endtask

    task automatic test_blink;
        logic [6:0] tab [3];
        logic [6:0] exp_seg;
        logic [2:0] exp_an;
        logic       exp_blk;
        int c0, off;
        tab[0] = 7'h6D; tab[1] = 7'h66; tab[2] = 7'h3F;
        advance_to(72);
        bus.isGameComplete = 1'b1;
        @(negedge clk);
        c0 = cyc;
        bus.isGameComplete = 1'b0;
        set_digits(4'd0, 4'd4, 4'd5);
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            off = cyc - c0;
            exp_blk = (off <= 32);
            if ((off >= 1 && off <= 8) || (off >= 17 && off <= 24)) begin
                exp_an = 3'b000; exp_seg = 7'h00;
            end else begin
                exp_an = 3'b001 << slot_of(cyc); exp_seg = tab[slot_of(cyc)];
            end
            checks++;
            if (bus.an !== exp_an) begin
                errors++; $display("FAIL blink_an off=%0d got=%b exp=%b", off, bus.an, exp_an);
            end
            checks++;
            if (bus.seg !== exp_seg) begin
                errors++; $display("FAIL blink_seg off=%0d got=%h exp=%h", off, bus.seg, exp_seg);
            end
            checks++;
            if (bus.blinking !== exp_blk) begin
                errors++; $display("FAIL blink_flag off=%0d got=%b exp=%b", off, bus.blinking, exp_blk);
            end
        end
    endtask

    task automatic test_blink_restart;
        logic [2:0] exp_an;
        int c1, c2, off;
        @(negedge clk);
        bus.isGameComplete = 1'b1;
        @(negedge clk);
        c1 = cyc;
        repeat (2) @(negedge clk);
        bus.isGameComplete = 1'b0;
        advance_to(c1 + 8);
        checks++;
        if (bus.an !== 3'b000) begin errors++; $display("FAIL level_off_an got=%b exp=000", bus.an); end
        @(negedge clk);
        exp_an = 3'b001 << slot_of(cyc);
        checks++;
        if (bus.an !== exp_an) begin errors++; $display("FAIL level_on_an got=%b exp=%b", bus.an, exp_an); end
        advance_to(c1 + 10);
        bus.isGameComplete = 1'b1;
        @(negedge clk);
        c2 = cyc;
        bus.isGameComplete = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            off = cyc - c2;
            exp_an = (off <= 8) ? 3'b000 : (3'b001 << slot_of(cyc));
            checks++;
            if (bus.an !== exp_an) begin
                errors++; $display("FAIL restart_an off=%0d got=%b exp=%b", off, bus.an, exp_an);
            end
            checks++;
            if (bus.blinking !== 1'b1) begin
                errors++; $display("FAIL restart_blinking off=%0d got=%b exp=1", off, bus.blinking);
            end
        end
    endtask

    task automatic test_mid_blink_reset;
        #2 nRst = 1'b0;
        #1;
        checks++;
        if (bus.seg !== 7'h00) begin errors++; $display("FAIL midreset_seg got=%h exp=00", bus.seg); end
        checks++;
        if (bus.an !== 3'b000) begin errors++; $display("FAIL midreset_an got=%b exp=000", bus.an); end
        checks++;
        if (bus.blinking !== 1'b0) begin errors++; $display("FAIL midreset_blinking got=%b exp=0", bus.blinking); end
        set_digits(4'd0, 4'd0, 4'd7);
        repeat (2) @(negedge clk);
        nRst = 1'b1;
    endtask

    task automatic test_leading_zeros;
        logic [6:0] exp_seg;
        int s;
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            if (cyc == 24) set_digits(4'd0, 4'd5, 4'd0);
            s = slot_of(cyc);
            if (s == 2)
                exp_seg = LZB ? 7'h00 : 7'h3F;
            else if (s == 1)
                exp_seg = (cyc > 36) ? 7'h6D : (LZB ? 7'h00 : 7'h3F);
            else
                exp_seg = (cyc > 12 && cyc <= 36) ? 7'h07 : 7'h3F;
            checks++;
            if (bus.an !== (3'b001 << s)) begin
                errors++; $display("FAIL lzb_an cyc=%0d got=%b exp=%b", cyc, bus.an, 3'b001 << s);
            end
            checks++;
            if (bus.seg !== exp_seg) begin
                errors++; $display("FAIL lzb_seg cyc=%0d got=%h exp=%h", cyc, bus.seg, exp_seg);
            end
            checks++;
            if (bus.blinking !== 1'b0) begin
                errors++; $display("FAIL lzb_blinking cyc=%0d got=%b exp=0", cyc, bus.blinking);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_scan_order();
        test_no_tearing();
        test_invalid_bcd();
        test_blink();
        test_blink_restart();
        test_mid_blink_reset();
        test_leading_zeros();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
